// File: rtl/i2s_rx_deserializer.sv
// WM8731 ADC-side serial receiver: deserialises ADCDAT framed by ADCLRCK into
// signed left/right sample pairs delivered over a valid/ready handshake.
module i2s_rx_deserializer #(
  parameter int unsigned DATA_W   = 16,
  parameter bit          LEFT_LVL = 1'b0,
  parameter int unsigned MSB_DLY  = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_lrc,
  input  logic                     i_data,
  input  logic                     i_ready,
  input  logic                     i_clr_err,
  output logic signed [DATA_W-1:0] o_left,
  output logic signed [DATA_W-1:0] o_right,
  output logic                     o_valid,
  output logic                     o_frame_err,
  output logic                     o_overrun
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {SYNC, SHIFT, WAIT} state_e;

  state_e              state_q;
  logic                lrc_q;
  logic                chan_left_q;
  logic                left_done_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   left_hold_q;
  logic [DATA_W-1:0]   left_q;
  logic [DATA_W-1:0]   right_q;
  logic                valid_q;
  logic                frame_err_q;
  logic                overrun_q;

  logic                boundary;
  logic                new_left;
  logic                last_bit;
  logic [DATA_W-1:0]   shift_d;
  logic [DATA_W-1:0]   start_word;
  logic [CNT_W-1:0]    start_cnt;

  assign boundary   = (i_lrc != lrc_q);
  assign new_left   = (i_lrc == LEFT_LVL);
  assign last_bit   = (cnt_q == CNT_W'(DATA_W - 1));
  assign shift_d    = {shift_q[DATA_W-2:0], i_data};
  assign start_word = {{(DATA_W-1){1'b0}}, i_data};
  // The boundary cycle itself is the skipped slot in I2S mode, so the MSB
  // lands one BCLK after the LRC edge; left-justified mode captures it here.
  assign start_cnt  = (MSB_DLY == 0) ? CNT_W'(1) : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= SYNC;
      lrc_q       <= 1'b0;
      chan_left_q <= 1'b0;
      left_done_q <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      lrc_q <= i_lrc;
      if (valid_q && i_ready) valid_q <= 1'b0;
      if (i_clr_err) begin
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
      if (!i_en) begin
        state_q     <= SYNC;
        cnt_q       <= '0;
        left_done_q <= 1'b0;
      end else begin
        unique case (state_q)
          SYNC: begin
            if (boundary && new_left) begin
              state_q     <= SHIFT;
              chan_left_q <= 1'b1;
              cnt_q       <= start_cnt;
              shift_q     <= start_word;
            end
          end
          SHIFT: begin
            if (boundary) begin
              frame_err_q <= 1'b1;
              if (chan_left_q) left_done_q <= 1'b0;
              chan_left_q <= new_left;
              cnt_q       <= start_cnt;
              shift_q     <= start_word;
            end else begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + CNT_W'(1);
              if (last_bit) begin
                state_q <= WAIT;
                if (chan_left_q) begin
                  left_hold_q <= shift_d;
                  left_done_q <= 1'b1;
                end else begin
                  left_done_q <= 1'b0;
                  if (left_done_q) begin
                    if (!valid_q || i_ready) begin
                      left_q  <= left_hold_q;
                      right_q <= shift_d;
                      valid_q <= 1'b1;
                    end else begin
                      overrun_q <= 1'b1;
                    end
                  end
                end
              end
            end
          end
          WAIT: begin
            if (boundary) begin
              state_q     <= SHIFT;
              chan_left_q <= new_left;
              cnt_q       <= start_cnt;
              shift_q     <= start_word;
            end
          end
          default: state_q <= SYNC;
        endcase
      end
    end
  end

  assign o_left      = left_q;
  assign o_right     = right_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Scoreboard bench for i2s_rx_deserializer: an I2S-mode and a left-justified
// instance, directed frames with expected pairs queued at issue time.
module tb_i2s_rx_deserializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_err = 1'b0;

  logic en0 = 1'b1, lrc0 = 1'b1, data0 = 1'b0, ready0 = 1'b1;
  logic signed [15:0] left0, right0;
  logic valid0, ferr0, ovr0;

  logic en1 = 1'b0, lrc1 = 1'b1, data1 = 1'b0, ready1 = 1'b1;
  logic signed [15:0] left1, right1;
  logic valid1, ferr1, ovr1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  i2s_rx_deserializer #(.DATA_W(16), .LEFT_LVL(1'b0), .MSB_DLY(1)) dut_i2s (
    .i_clk(clk), .i_rst(rst), .i_en(en0), .i_lrc(lrc0), .i_data(data0),
    .i_ready(ready0), .i_clr_err(clr_err), .o_left(left0), .o_right(right0),
    .o_valid(valid0), .o_frame_err(ferr0), .o_overrun(ovr0)
  );

  i2s_rx_deserializer #(.DATA_W(16), .LEFT_LVL(1'b0), .MSB_DLY(0)) dut_lj (
    .i_clk(clk), .i_rst(rst), .i_en(en1), .i_lrc(lrc1), .i_data(data1),
    .i_ready(ready1), .i_clr_err(clr_err), .o_left(left1), .o_right(right1),
    .o_valid(valid1), .o_frame_err(ferr1), .o_overrun(ovr1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitors: a pair is consumed on every cycle with valid and ready high.
  always @(negedge clk) begin
    #1;
    if (valid0 && ready0) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL i2s_unexpected_pair: got %h, expected no pair", {left0, right0});
      end else begin
        chk("i2s_pair", {left0, right0}, q0.pop_front());
      end
    end
    if (valid1 && ready1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL lj_unexpected_pair: got %h, expected no pair", {left1, right1});
      end else begin
        chk("lj_pair", {left1, right1}, q1.pop_front());
      end
    end
  end

  task automatic drive(input bit lj, input bit lvl, input bit d);
    if (lj) begin
      lrc1  = lvl;
      data1 = d;
    end else begin
      lrc0  = lvl;
      data0 = d;
    end
  endtask

  // One channel of n BCLKs; the MSB sits dly cycles after the LRC change.
  task automatic send_ch(input bit lj, input bit lvl, input logic [15:0] w,
                         input int n, input int dly, input bit mark);
    for (int k = 0; k < n; k++) begin
      int j;
      bit b;
      j = k - dly;
      b = (j >= 0 && j < 16) ? w[15-j] : 1'b0;
      @(negedge clk);
      drive(lj, lvl, b);
      if (mark && k == dly + 15) begin
        #1 chk("valid_low_at_lsb", {31'd0, valid0}, 32'd0);
      end
      if (mark && k == dly + 16) begin
        #1 chk("valid_one_cycle_after_lsb", {31'd0, valid0}, 32'd1);
      end
    end
  endtask

  task automatic send_frame(input bit lj, input logic [15:0] l, input logic [15:0] r,
                            input int dly, input bit mark, input bit expect_pair);
    if (expect_pair) begin
      if (lj) q1.push_back({l, r});
      else    q0.push_back({l, r});
    end
    send_ch(lj, 1'b0, l, 32, dly, 1'b0);
    send_ch(lj, 1'b1, r, 32, dly, mark);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_left",  {16'd0, left0},  32'd0);
    chk("rst_right", {16'd0, right0}, 32'd0);
    chk("rst_valid", {31'd0, valid0}, 32'd0);
    chk("rst_ferr",  {31'd0, ferr0},  32'd0);
    chk("rst_ovr",   {31'd0, ovr0},   32'd0);
    chk("rst_lj_valid", {31'd0, valid1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // I2S frames with latency check on the first
    send_frame(1'b0, 16'h8001, 16'h7FFE, 1, 1'b1, 1'b1);
    send_frame(1'b0, 16'h8001, 16'h7FFE, 1, 1'b0, 1'b1);

    // Capture enabled mid-right channel
    en0 = 1'b0;
    send_ch(1'b0, 1'b0, 16'h9999, 32, 1, 1'b0);
    send_ch(1'b0, 1'b1, 16'h3333, 16, 1, 1'b0);
    en0 = 1'b1;
    send_ch(1'b0, 1'b1, 16'h0000, 16, 1, 1'b0);
    send_frame(1'b0, 16'h1234, 16'h5678, 1, 1'b0, 1'b1);
    send_frame(1'b0, 16'hABCD, 16'h0F0F, 1, 1'b0, 1'b1);
    #1 chk("resync_no_ferr", {31'd0, ferr0}, 32'd0);

    // Left-justified instance
    en1 = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(1'b1, 16'hFFFF, 16'h0001, 0, 1'b0, 1'b1);
    #1 chk("lj_left_held", {16'd0, left1}, 32'h0000FFFF);

    // Truncated left channel
    send_ch(1'b0, 1'b0, 16'h7777, 10, 1, 1'b0);
    send_ch(1'b0, 1'b1, 16'h6666, 32, 1, 1'b0);
    #1 chk("trunc_ferr_set", {31'd0, ferr0}, 32'd1);
    send_frame(1'b0, 16'h1111, 16'h2222, 1, 1'b0, 1'b1);
    #1 chk("trunc_ferr_sticky", {31'd0, ferr0}, 32'd1);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1 chk("ferr_cleared", {31'd0, ferr0}, 32'd0);

    // Overrun with consumer stalled
    ready0 = 1'b0;
    send_frame(1'b0, 16'hAAAA, 16'h5555, 1, 1'b0, 1'b1);
    send_frame(1'b0, 16'h1111, 16'h2222, 1, 1'b0, 1'b0);
    #1;
    chk("ovr_set",        {31'd0, ovr0},   32'd1);
    chk("ovr_valid_held", {31'd0, valid0}, 32'd1);
    chk("ovr_pair_held",  {left0, right0}, 32'hAAAA5555);
    @(negedge clk);
    ready0 = 1'b1;
    @(negedge clk);
    #1 chk("ovr_valid_drop", {31'd0, valid0}, 32'd0);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1 chk("ovr_cleared", {31'd0, ovr0}, 32'd0);

    // Reset during a left-channel shift
    send_ch(1'b0, 1'b0, 16'h4321, 10, 1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_pair",     {left0, right0}, 32'd0);
    chk("midrst_valid",    {31'd0, valid0}, 32'd0);
    chk("midrst_lj_left",  {16'd0, left1},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_ch(1'b0, 1'b0, 16'h4321, 21, 1, 1'b0);
    send_ch(1'b0, 1'b1, 16'h4444, 32, 1, 1'b0);
    send_frame(1'b0, 16'h5A5A, 16'hA5A5, 1, 1'b0, 1'b1);

    repeat (10) @(negedge clk);
    #1;
    chk("i2s_queue_drained", q0.size(), 32'd0);
    chk("lj_queue_drained",  q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
